// File: rtl/level2_pkg.sv
// Shared types and constants for the Level2CU step controller.
package level2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] STEP0 = 2'b00;
  localparam logic [1:0] STEP1 = 2'b01;
  localparam logic [1:0] STEP2 = 2'b10;

  // Word layout: [DATA_W-1:DATA_W-TAG_W] tag, remaining low bits distance.
  localparam int TAG_W = 3;

  // Distance field width for a given word width.
  function automatic int dist_w(input int data_w);
    return data_w - TAG_W;
  endfunction

  // Step sequence 00 -> 01 -> 10 -> 00; code 11 never produced.
  function automatic logic [1:0] next_step(input logic [1:0] s);
    case (s)
      STEP0:   return STEP1;
      STEP1:   return STEP2;
      default: return STEP0;
    endcase
  endfunction

endpackage

// File: rtl/level2_step_ctrl.sv
// Sequencing controller for the 4-node Level2CU relaxation network.
// Holds A..D, steps the network 00/01/10 per round, feeds results back and
// presents the converged (or round-limited) vector with a valid/ready handshake.
module level2_step_ctrl
  import level2_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MAX_ROUNDS = 3,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_c,
  input  logic [DATA_W-1:0] in_d,
  output logic [1:0]        step_counter,
  output logic [DATA_W-1:0] cu_a,
  output logic [DATA_W-1:0] cu_b,
  output logic [DATA_W-1:0] cu_c,
  output logic [DATA_W-1:0] cu_d,
  input  logic [DATA_W-1:0] cu_ao,
  input  logic [DATA_W-1:0] cu_bo,
  input  logic [DATA_W-1:0] cu_co,
  input  logic [DATA_W-1:0] cu_do,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_c,
  output logic [DATA_W-1:0] out_d,
  output logic [3:0]        rounds_used
);

  localparam logic [3:0] LAST_ROUND = 4'(MAX_ROUNDS);

  state_t            state;
  logic [DATA_W-1:0] reg_a;
  logic [DATA_W-1:0] reg_b;
  logic [DATA_W-1:0] reg_c;
  logic [DATA_W-1:0] reg_d;
  logic [1:0]        step;
  logic [3:0]        round_cnt;
  logic              chg;

  logic              any_chg;
  logic              chg_round;
  logic              exit_now;

  // Change detection over full words (tags included) and round exit decision.
  always_comb begin
    any_chg   = (cu_ao != reg_a) | (cu_bo != reg_b) |
                (cu_co != reg_c) | (cu_do != reg_d);
    chg_round = chg | any_chg;
    exit_now  = (EARLY_EXIT && !chg_round) || ((round_cnt + 4'd1) == LAST_ROUND);
  end

  // Registers are the network operands and the presented result at once.
  assign cu_a         = reg_a;
  assign cu_b         = reg_b;
  assign cu_c         = reg_c;
  assign cu_d         = reg_d;
  assign out_a        = reg_a;
  assign out_b        = reg_b;
  assign out_c        = reg_c;
  assign out_d        = reg_d;
  assign step_counter = step;
  assign rounds_used  = round_cnt;

  // Controller FSM: load in IDLE, relax in RUN, hold result in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      reg_a     <= '0;
      reg_b     <= '0;
      reg_c     <= '0;
      reg_d     <= '0;
      step      <= STEP0;
      round_cnt <= '0;
      chg       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            reg_a     <= in_a;
            reg_b     <= in_b;
            reg_c     <= in_c;
            reg_d     <= in_d;
            step      <= STEP0;
            round_cnt <= '0;
            chg       <= 1'b0;
            in_ready  <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          reg_a <= cu_ao;
          reg_b <= cu_bo;
          reg_c <= cu_co;
          reg_d <= cu_do;
          if (step == STEP2) begin
            // Round boundary: the step-10 compare is part of this round.
            round_cnt <= round_cnt + 4'd1;
            step      <= STEP0;
            chg       <= 1'b0;
            if (exit_now) begin
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end else begin
            step <= next_step(step);
            chg  <= chg_round;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          step      <= STEP0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/level2_step_ctrl.md
Name: level2_step_ctrl

Overview:
Sequencing controller for the 4-node Level2CU relaxation network.
- Accepts a 4-word distance vector (A,B,C,D), holds it in registers and drives the network.
- Steps the network through step codes 00 -> 01 -> 10 once per clock.
- Feeds the network outputs back into its registers; ends on convergence or a round limit, then presents the result.
- Sits between the bf16x16 upper-level scheduler and one Level2CU instance in the parent.

Parameters:
DATA_W, 32, word width; [DATA_W-1:DATA_W-3] tag, [DATA_W-4:0] distance
MAX_ROUNDS, 3, maximum relaxation rounds (1 round = 3 steps); range 1..15
EARLY_EXIT, 1, 1 = stop after the first round with no register change; 0 = always run MAX_ROUNDS

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input vector valid
in_ready  out  1  controller can accept a vector
in_a, in_b, in_c, in_d  in  DATA_W  initial node words
step_counter  out  2  step code to Level2CU
cu_a, cu_b, cu_c, cu_d  out  DATA_W  registered words driving Level2CU A..D
cu_ao, cu_bo, cu_co, cu_do  in  DATA_W  Level2CU outputs Ao..Do (combinational from cu_*/step_counter)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_a, out_b, out_c, out_d  out  DATA_W  final words
rounds_used  out  4  rounds executed for current result

Behaviour:
- Reset (async, any state):
  - state=IDLE; regs A..D=0; step_counter=00; round_cnt=0; chg=0.
  - out_valid=0; in_ready=1 after reset release; rounds_used=0.
- States: IDLE, RUN, DONE. cu_* = regs at all times. out_* = regs. rounds_used = round_cnt.
- IDLE:
  - in_ready=1, step_counter=00.
  - On in_valid: load regs<=in_*, step<=00, round_cnt<=0, chg<=0, go to RUN.
- RUN (in_ready=0):
  - Each cycle: regs<=cu_*o; chg<=chg | (any cu_*o != reg, full DATA_W compare).
  - Step advances 00->01->10->00. Code 11 is never issued.
- End of round (the cycle step==10 is captured):
  - round_cnt<=round_cnt+1.
  - Exit to DONE if (EARLY_EXIT && !chg_this_round) or round_cnt+1==MAX_ROUNDS; otherwise stay in RUN, clear chg, step<=00.
  - chg_this_round includes the step-10 compare.
- DONE:
  - out_valid=1; step_counter=00; regs frozen.
  - Data is stable while out_valid && !out_ready.
  - On out_ready: go to IDLE; out_valid drops next cycle.
- in_ready is 0 in DONE, so no same-cycle handoff. A new vector is accepted in IDLE, one cycle after out_ready.
- Latency:
  - Accept at cycle 0; RUN occupies cycles 1..3R, where R = rounds executed; out_valid is high from cycle 3R+1.
  - Minimum R=1, since the first round always runs.
- The controller never modifies tag bits; it stores whatever the network returns.
- in_valid during RUN/DONE is ignored and not stored; the source must hold it.

Decomposition:
- Package level2_pkg:
  - state enum {IDLE,RUN,DONE};
  - step constants STEP0=2'b00, STEP1=2'b01, STEP2=2'b10;
  - TAG_W=3, DIST_W=DATA_W-3.
- Single module with one FSM, a 2-bit step counter and a 4-bit round counter. No sub-module.
- Level2CU is instantiated alongside this block in the parent, not inside it.

Test Plan:
- Identity stub (cu_*o = cu_*), in_a..d = 1,2,3,4, EARLY_EXIT=1:
  - step_counter = 00,01,10;
  - out_valid at cycle 4;
  - out = 1,2,3,4; rounds_used=1.
- Increment stub (each output = input+1), in = 0,10,20,30, MAX_ROUNDS=3:
  - out_valid at cycle 10;
  - out = 9,19,29,39; rounds_used=3;
  - step sequence 00,01,10 repeated 3 times.
- Identity stub, EARLY_EXIT=0: rounds_used=3; out_valid at cycle 10; out = inputs.
- Backpressure: hold out_ready=0 for 5 cycles in DONE:
  - out_valid and out_* stable, in_ready=0;
  - after out_ready=1, in_ready=1 next cycle and a new vector is accepted then.
- Reset asserted mid-RUN (cycle 2):
  - in the same cycle: step_counter=00, regs=0, out_valid=0;
  - after release: in_ready=1, and a fresh run completes normally.
- Stub that changes only cu_do on step 01 of round 1, then is identity:
  - exits after round 2; rounds_used=2; out_valid at cycle 7.
